// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: alignment state, queue entry layout and
// halfword classification used by the fetch aligner and its queue.
package cpu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned HALF_W = 16;

    // RVC quadrant value that marks a halfword as the start of a 32-bit (or longer) instruction
    localparam logic [1:0] QUADRANT_FULL = 2'b11;

    typedef enum logic {
        ALIGN_EMPTY = 1'b0,
        ALIGN_HALF  = 1'b1
    } align_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            compressed;
        logic            illegal;
    } queue_entry_t;

    // 48/64-bit encodings share the 2'b11 quadrant and are handled as 32-bit
    function automatic logic is_compressed(input logic [HALF_W-1:0] hw);
        return hw[1:0] != QUADRANT_FULL;
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Instruction queue with two ordered write ports and one read port.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             empties the queue at the clock edge
//   wr0_en/wr0_data   first push of the cycle (lower address)
//   wr1_en/wr1_data   second push of the cycle, only used together with wr0
//   rd_en             pop the head when non-empty
//   rd_data/rd_valid  current head entry and its valid flag
//   count             registered occupancy
module instr_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr0_en,
    input  queue_entry_t                 wr0_data,
    input  logic                         wr1_en,
    input  queue_entry_t                 wr1_data,
    input  logic                         rd_en,
    output queue_entry_t                 rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    queue_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr_p1;
    logic             pop;

    assign pop      = rd_en && (count != '0);
    assign wptr_p1  = wptr + PTR_W'(1);
    assign rd_data  = mem[rptr];
    assign rd_valid = (count != '0);

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr0_en) begin
                mem[wptr] <= wr0_data;
            end
            if (wr1_en) begin
                mem[wptr_p1] <= wr1_data;
            end
            wptr  <= wptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Instruction alignment stage: splits 32-bit fetch words into 16-bit and
// 32-bit instructions (including ones straddling two words) and queues them.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               drop queue contents and any leftover halfword
//   fetch_valid/ready   fetch word handshake
//   fetch_data/pc       fetch word and address of its first useful halfword
//   out_valid/ready     decoder handshake on the queue head
//   out_instr/pc        raw instruction and its address
//   out_compressed      head is a 16-bit instruction
//   out_illegal         head is misaligned or unsupported
module fetch_aligner
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter bit          COMPRESSED = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [XLEN-1:0] fetch_data,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_compressed,
    output logic            out_illegal
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    align_state_t      align_state, state_nx;
    logic [HALF_W-1:0] left_hw, left_hw_nx;
    logic [XLEN-1:0]   left_pc, left_pc_nx;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  free;
    logic              accept;
    logic              wr0_en, wr1_en;
    queue_entry_t      wr0_data, wr1_data, head;

    logic [HALF_W-1:0] lo_hw, hi_hw;
    logic              straddle;
    logic              hi_go;
    logic [XLEN-1:0]   hi_pc;
    queue_entry_t      hi_entry;

    // Two free slots are required since one word can produce two entries
    assign free        = CNT_W'(DEPTH) - count;
    assign fetch_ready = !reset && !flush && (free >= CNT_W'(2));
    assign accept      = fetch_valid && fetch_ready;

    assign lo_hw    = fetch_data[HALF_W-1:0];
    assign hi_hw    = fetch_data[XLEN-1:HALF_W];
    assign straddle = (align_state == ALIGN_HALF) && (fetch_pc == left_pc + 32'd2);

    // Word parsing: up to two pushes in address order plus the next alignment state
    always_comb begin
        state_nx   = align_state;
        left_hw_nx = left_hw;
        left_pc_nx = left_pc;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        wr0_data   = '0;
        wr1_data   = '0;
        hi_go      = 1'b0;
        hi_pc      = '0;
        hi_entry   = '0;

        if (accept) begin
            if (fetch_pc[0]) begin
                wr0_en           = 1'b1;
                wr0_data.instr   = fetch_data;
                wr0_data.pc      = fetch_pc;
                wr0_data.illegal = 1'b1;
                state_nx         = ALIGN_EMPTY;
            end else if (!COMPRESSED) begin
                wr0_en           = 1'b1;
                wr0_data.instr   = fetch_data;
                wr0_data.pc      = fetch_pc;
                wr0_data.illegal = (lo_hw[1:0] != QUADRANT_FULL) || fetch_pc[1];
                state_nx         = ALIGN_EMPTY;
            end else if (straddle) begin
                wr0_en         = 1'b1;
                wr0_data.instr = {lo_hw, left_hw};
                wr0_data.pc    = left_pc;
                hi_go          = 1'b1;
                hi_pc          = fetch_pc + 32'd2;
            end else if (!fetch_pc[1]) begin
                // Any stale leftover that does not continue here is dropped
                wr0_en      = 1'b1;
                wr0_data.pc = fetch_pc;
                if (is_compressed(lo_hw)) begin
                    wr0_data.instr      = {16'h0000, lo_hw};
                    wr0_data.compressed = 1'b1;
                    hi_go               = 1'b1;
                    hi_pc               = fetch_pc + 32'd2;
                end else begin
                    wr0_data.instr = fetch_data;
                    state_nx       = ALIGN_EMPTY;
                end
            end else begin
                hi_go = 1'b1;
                hi_pc = fetch_pc;
            end

            if (hi_go) begin
                if (is_compressed(hi_hw)) begin
                    hi_entry.instr      = {16'h0000, hi_hw};
                    hi_entry.pc         = hi_pc;
                    hi_entry.compressed = 1'b1;
                    if (wr0_en) begin
                        wr1_en   = 1'b1;
                        wr1_data = hi_entry;
                    end else begin
                        wr0_en   = 1'b1;
                        wr0_data = hi_entry;
                    end
                    state_nx = ALIGN_EMPTY;
                end else begin
                    left_hw_nx = hi_hw;
                    left_pc_nx = hi_pc;
                    state_nx   = ALIGN_HALF;
                end
            end
        end
    end

    // Alignment state; reset and flush both discard a pending leftover
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            align_state <= ALIGN_EMPTY;
            left_hw     <= '0;
            left_pc     <= '0;
        end else begin
            align_state <= state_nx;
            left_hw     <= left_hw_nx;
            left_pc     <= left_pc_nx;
        end
    end

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (out_ready),
        .rd_data  (head),
        .rd_valid (out_valid),
        .count    (count)
    );

    assign out_instr      = head.instr;
    assign out_pc         = head.pc;
    assign out_compressed = head.compressed;
    assign out_illegal    = head.illegal;

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: a C-enabled instance and a 32-bit-only instance.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        reset, flush;

    logic        fetch_valid, fetch_ready, out_valid, out_ready, out_compressed, out_illegal;
    logic [31:0] fetch_data, fetch_pc, out_instr, out_pc;

    logic        nc_fetch_valid, nc_fetch_ready, nc_out_valid, nc_out_ready, nc_out_compressed, nc_out_illegal;
    logic [31:0] nc_fetch_data, nc_fetch_pc, nc_out_instr, nc_out_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_aligner #(.DEPTH(4), .COMPRESSED(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_data(fetch_data), .fetch_pc(fetch_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_compressed(out_compressed), .out_illegal(out_illegal)
    );

    fetch_aligner #(.DEPTH(4), .COMPRESSED(1'b0)) dut_nc (
        .clk(clk), .reset(reset), .flush(flush),
        .fetch_valid(nc_fetch_valid), .fetch_ready(nc_fetch_ready),
        .fetch_data(nc_fetch_data), .fetch_pc(nc_fetch_pc),
        .out_valid(nc_out_valid), .out_ready(nc_out_ready),
        .out_instr(nc_out_instr), .out_pc(nc_out_pc),
        .out_compressed(nc_out_compressed), .out_illegal(nc_out_illegal)
    );

    // Present one word (called at a negedge); waits a bounded time for fetch_ready
    task automatic send_word(input bit nc, input logic [31:0] d, input logic [31:0] pc);
        for (int t = 0; t < 20; t++) begin
            if ((nc ? nc_fetch_ready : fetch_ready) === 1'b1) break;
            @(negedge clk);
        end
        if (nc) begin
            nc_fetch_valid = 1'b1; nc_fetch_data = d; nc_fetch_pc = pc;
        end else begin
            fetch_valid = 1'b1; fetch_data = d; fetch_pc = pc;
        end
        @(negedge clk);
        fetch_valid    = 1'b0;
        nc_fetch_valid = 1'b0;
    endtask

    // Wait (bounded) for a head entry, return {found, instr, pc, compressed, illegal}, then pop it
    task automatic pop_head(input bit nc, output logic [66:0] got);
        bit ok = 1'b0;
        got = '0;
        for (int t = 0; t < 20; t++) begin
            if ((nc ? nc_out_valid : out_valid) === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        if (nc) got = {1'b1, nc_out_instr, nc_out_pc, nc_out_compressed, nc_out_illegal};
        else    got = {1'b1, out_instr, out_pc, out_compressed, out_illegal};
        if (nc) nc_out_ready = 1'b1; else out_ready = 1'b1;
        @(negedge clk);
        out_ready    = 1'b0;
        nc_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0;
        fetch_valid = 1'b0; fetch_data = '0; fetch_pc = '0; out_ready = 1'b0;
        nc_fetch_valid = 1'b0; nc_fetch_data = '0; nc_fetch_pc = '0; nc_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b exp 0", fetch_ready); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
        n_checks++;
        if ({out_valid, out_instr, out_pc, out_compressed, out_illegal} !== 67'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp 0", {out_valid, out_instr, out_pc, out_compressed, out_illegal});
        end
        @(negedge clk);
    endtask

    task automatic test_full_words();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h0000_0013, 32'h0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_latency got %b exp 1", out_valid); end
        send_word(1'b0, 32'h0010_0093, 32'h4);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL full_w0 got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL full_w1 got %h exp %h", got, exp); end
    endtask

    task automatic test_compressed_pair();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h4501_4501, 32'h100);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h100, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pair_lo got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h102, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL pair_hi got %h exp %h", got, exp); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pair_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_straddle();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h0013_4501, 32'h200);
        send_word(1'b0, 32'h4501_0000, 32'h204);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h200, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL strad_c0 got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_0013, 32'h202, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL strad_full got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h206, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL strad_c1 got %h exp %h", got, exp); end
    endtask

    task automatic test_upper_start();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h4501_0000, 32'h302);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h302, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL upper_half got %h exp %h", got, exp); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL upper_single got %b exp 0", out_valid); end
        send_word(1'b0, 32'h1234_5678, 32'h301);
        pop_head(1'b0, got); exp = {1'b1, 32'h1234_5678, 32'h301, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL misaligned got %h exp %h", got, exp); end
    endtask

    task automatic test_pc_mismatch();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h0013_4501, 32'h800);
        send_word(1'b0, 32'h0000_0013, 32'h900);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h800, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mism_c got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_0013, 32'h900, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL mism_fresh got %h exp %h", got, exp); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mism_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [66:0] got, exp;
        logic [31:0] pcs [4];
        pcs[0] = 32'h600; pcs[1] = 32'h602; pcs[2] = 32'h604; pcs[3] = 32'h606;
        send_word(1'b0, 32'h4501_4501, 32'h600);
        n_checks++;
        if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_at2 got %b exp 1", fetch_ready); end
        send_word(1'b0, 32'h4501_4501, 32'h604);
        n_checks++;
        if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_at4 got %b exp 0", fetch_ready); end
        // Offer a word while full and watch the head hold still
        fetch_valid = 1'b1; fetch_data = 32'h0000_0013; fetch_pc = 32'h608;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_instr, out_pc} !== {1'b1, 32'h0000_4501, 32'h600}) begin
                n_fail++; $display("FAIL bp_stable got %h exp %h", {out_valid, out_instr, out_pc}, {1'b1, 32'h0000_4501, 32'h600});
            end
        end
        fetch_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, pcs[k], 1'b1, 1'b0};
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL bp_drain%0d got %h exp %h", k, got, exp); end
        end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_blocked_word got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [66:0] got, exp;
        send_word(1'b0, 32'h0013_4501, 32'h700);
        flush = 1'b1;
        fetch_valid = 1'b1; fetch_data = 32'h4501_4501; fetch_pc = 32'h704;
        #1;
        n_checks++;
        if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", fetch_ready); end
        @(negedge clk);
        flush = 1'b0; fetch_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got %b exp 0", out_valid); end
        // Would complete the discarded straddle if the leftover survived
        send_word(1'b0, 32'h4501_0000, 32'h704);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_0000, 32'h704, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL flush_fresh_lo got %h exp %h", got, exp); end
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_4501, 32'h706, 1'b1, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL flush_fresh_hi got %h exp %h", got, exp); end
        send_word(1'b0, 32'h0000_0013, 32'h400);
        pop_head(1'b0, got); exp = {1'b1, 32'h0000_0013, 32'h400, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL flush_next got %h exp %h", got, exp); end
    endtask

    task automatic test_no_compressed();
        logic [66:0] got, exp;
        send_word(1'b1, 32'h0000_4501, 32'h500);
        pop_head(1'b1, got); exp = {1'b1, 32'h0000_4501, 32'h500, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL nc_quadrant got %h exp %h", got, exp); end
        send_word(1'b1, 32'h0000_0013, 32'h502);
        pop_head(1'b1, got); exp = {1'b1, 32'h0000_0013, 32'h502, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL nc_upper got %h exp %h", got, exp); end
        send_word(1'b1, 32'h0000_0013, 32'h504);
        pop_head(1'b1, got); exp = {1'b1, 32'h0000_0013, 32'h504, 1'b0, 1'b0};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL nc_legal got %h exp %h", got, exp); end
        send_word(1'b1, 32'h4501_4501, 32'h508);
        pop_head(1'b1, got); exp = {1'b1, 32'h4501_4501, 32'h508, 1'b0, 1'b1};
        n_checks++;
        if (got !== exp) begin n_fail++; $display("FAIL nc_one_entry got %h exp %h", got, exp); end
        n_checks++;
        if (nc_out_valid !== 1'b0) begin n_fail++; $display("FAIL nc_single got %b exp 0", nc_out_valid); end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_compressed_pair();
        test_straddle();
        test_upper_start();
        test_pc_mismatch();
        test_backpressure();
        test_flush();
        test_no_compressed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t exp completion", $time);
        $fatal(1);
    end

endmodule
